// File: rtl/mdu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : mdu_pkg
// Brief   : Shared operation and state encodings for the multiply/divide unit.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_cond_neg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : mdu_cond_neg
// Brief   : Parametrised-width conditional two's-complement negate.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module mdu_cond_neg #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  assign dout = en ? (~din + WIDTH'(1)) : din;

endmodule
`default_nettype wire

// File: rtl/mdu_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : mdu_sequencer
// Brief   : Radix-2 iterative signed/unsigned multiply/divide sequencer.
//           Define MDU_EARLY_OUT_EN to let multiplies stop once the remaining
//           multiplier bits are zero.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic              hilo_load,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  state_t                r_state;
  state_t                w_next;
  logic [1:0]            r_op;
  logic [DATA_W-1:0]     r_a;
  logic [DATA_W-1:0]     r_b;
  logic [DATA_W-1:0]     r_opnd;
  logic [2*DATA_W-1:0]   r_acc;
  logic [DATA_W:0]       r_rem;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_sign_lo;
  logic                  r_sign_hi;
  logic                  r_dz;
  logic [DATA_W-1:0]     r_hi;
  logic [DATA_W-1:0]     r_lo;

  logic                  w_is_div;
  logic                  w_is_signed;
  logic                  w_b_zero;
  logic [DATA_W-1:0]     w_a_abs;
  logic [DATA_W-1:0]     w_b_abs;
  logic [DATA_W:0]       w_sum;
  logic [2*DATA_W-1:0]   w_mul_acc;
  logic [DATA_W+1:0]     w_shift;
  logic [DATA_W+1:0]     w_diff;
  logic                  w_fits;
  logic [DATA_W:0]       w_div_rem;
  logic [DATA_W-1:0]     w_div_q;
  logic [CNT_W-1:0]      w_cnt_dec;
  logic                  w_iter_last;
  logic [2*DATA_W-1:0]   w_prod_raw;
  logic [2*DATA_W-1:0]   w_prod;
  logic [DATA_W-1:0]     w_quo;
  logic [DATA_W-1:0]     w_rmd;

  assign w_is_div    = op_is_div(r_op);
  assign w_is_signed = op_is_signed(r_op);
  assign w_b_zero    = (r_b == '0);

  mdu_cond_neg #(.WIDTH(DATA_W)) u_abs_a (
    .en   (w_is_signed & r_a[DATA_W-1]),
    .din  (r_a),
    .dout (w_a_abs)
  );

  mdu_cond_neg #(.WIDTH(DATA_W)) u_abs_b (
    .en   (w_is_signed & r_b[DATA_W-1]),
    .din  (r_b),
    .dout (w_b_abs)
  );

  // Multiply: low half of the accumulator holds the unconsumed multiplier bits.
  assign w_sum     = {1'b0, r_acc[2*DATA_W-1:DATA_W]}
                   + (r_acc[0] ? {1'b0, r_opnd} : {(DATA_W+1){1'b0}});
  assign w_mul_acc = {w_sum, r_acc[DATA_W-1:1]};

  // Divide: restoring step, quotient bits shift into the low accumulator half.
  assign w_shift   = {r_rem, r_acc[DATA_W-1]};
  assign w_diff    = w_shift - {2'b00, r_opnd};
  assign w_fits    = ~w_diff[DATA_W+1];
  assign w_div_rem = w_fits ? w_diff[DATA_W:0] : w_shift[DATA_W:0];
  assign w_div_q   = {r_acc[DATA_W-2:0], w_fits};

  assign w_cnt_dec = r_cnt - CNT_W'(1);

`ifdef MDU_EARLY_OUT_EN
  // Low w_cnt_dec bits of the next accumulator are the multiplier bits still to come.
  assign w_iter_last = (w_cnt_dec == '0) ||
                       (!w_is_div &&
                        ((w_mul_acc[DATA_W-1:0] & ~({DATA_W{1'b1}} << w_cnt_dec)) == '0));
  assign w_prod_raw  = r_acc >> r_cnt;
`else
  assign w_iter_last = (w_cnt_dec == '0);
  assign w_prod_raw  = r_acc;
`endif

  mdu_cond_neg #(.WIDTH(2*DATA_W)) u_fix_prod (
    .en   (r_sign_lo),
    .din  (w_prod_raw),
    .dout (w_prod)
  );

  mdu_cond_neg #(.WIDTH(DATA_W)) u_fix_quo (
    .en   (r_sign_lo),
    .din  (r_acc[DATA_W-1:0]),
    .dout (w_quo)
  );

  mdu_cond_neg #(.WIDTH(DATA_W)) u_fix_rem (
    .en   (r_sign_hi),
    .din  (r_rem[DATA_W-1:0]),
    .dout (w_rmd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    div_zero  = 1'b0;
    hilo_load = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = ST_PREP;
        end
      end
      ST_PREP: begin
        busy   = 1'b1;
        w_next = (w_is_div && w_b_zero) ? ST_DONE : ST_ITER;
      end
      ST_ITER: begin
        busy = 1'b1;
        if (w_iter_last) begin
          w_next = ST_FIX;
        end
      end
      ST_FIX: begin
        busy   = 1'b1;
        w_next = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        div_zero  = r_dz;
        hilo_load = ~r_dz;
        w_next    = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_sign_lo <= 1'b0;
      r_sign_hi <= 1'b0;
      r_dz      <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op <= op;
            r_a  <= a;
            r_b  <= b;
            r_dz <= 1'b0;
          end
        end
        ST_PREP: begin
          r_sign_lo <= w_is_signed & (r_a[DATA_W-1] ^ r_b[DATA_W-1]);
          r_sign_hi <= w_is_signed & w_is_div & r_a[DATA_W-1];
          r_dz      <= w_is_div & w_b_zero;
          r_rem     <= '0;
          if (!(w_is_div && w_b_zero)) begin
            r_cnt <= CNT_W'(DATA_W);
          end
          if (w_is_div) begin
            r_opnd <= w_b_abs;
            r_acc  <= {{DATA_W{1'b0}}, w_a_abs};
          end else begin
            r_opnd <= w_a_abs;
            r_acc  <= {{DATA_W{1'b0}}, w_b_abs};
          end
        end
        ST_ITER: begin
          r_cnt <= w_cnt_dec;
          if (w_is_div) begin
            r_rem             <= w_div_rem;
            r_acc[DATA_W-1:0] <= w_div_q;
          end else begin
            r_acc <= w_mul_acc;
          end
        end
        ST_FIX: begin
          if (w_is_div) begin
            r_hi <= w_rmd;
            r_lo <= w_quo;
          end else begin
            r_hi <= w_prod[2*DATA_W-1:DATA_W];
            r_lo <= w_prod[DATA_W-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule
`default_nettype wire
